// File: rtl/sram_port_arbiter.sv
// Shares one registered-command SRAM port between the SIFT pipeline and the EPP host
// (write and read channels), with a host starvation counter and tagged read returns.
module sram_port_arbiter #(
    parameter int AW       = 23,
    parameter int DW       = 8,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pl_req,
    input  logic          pl_we,
    input  logic [AW-1:0] pl_addr,
    input  logic [DW-1:0] pl_wdata,
    output logic          pl_gnt,
    output logic          pl_rvalid,
    output logic [DW-1:0] pl_rdata,
    input  logic          hw_req,
    input  logic [AW-1:0] hw_addr,
    input  logic [DW-1:0] hw_wdata,
    output logic          hw_gnt,
    input  logic          hr_req,
    input  logic [AW-1:0] hr_addr,
    output logic          hr_gnt,
    output logic          hr_rvalid,
    output logic [DW-1:0] hr_rdata,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata,
    output logic          host_starved
);
    typedef enum logic {PL_PRI = 1'b0, HOST_PRI = 1'b1} state_t;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    state_t          state, state_nxt;
    logic [7:0]      wait_cnt, wait_nxt;
    logic            host_gnt, host_req, rd_push;
    logic [RD_LAT:0] tag_vld, tag_host;
    logic [DW-1:0]   pl_hold, hr_hold;

    always_comb begin
        pl_gnt = 1'b0;
        hw_gnt = 1'b0;
        hr_gnt = 1'b0;
        if (!rst) begin
            if (state == PL_PRI) begin
                if (pl_req)      pl_gnt = 1'b1;
                else if (hw_req) hw_gnt = 1'b1;
                else if (hr_req) hr_gnt = 1'b1;
            end else begin
                if (hw_req)      hw_gnt = 1'b1;
                else if (hr_req) hr_gnt = 1'b1;
                else if (pl_req) pl_gnt = 1'b1;
            end
        end
    end

    assign host_gnt = hw_gnt | hr_gnt;
    assign host_req = hw_req | hr_req;
    assign rd_push  = (pl_gnt & ~pl_we) | hr_gnt;

    // A host grant clears the counter even in the cycle it would have promoted the host.
    always_comb begin
        wait_nxt  = wait_cnt;
        state_nxt = state;
        if (host_gnt)
            wait_nxt = 8'd0;
        else if (host_req && wait_cnt != WAIT_MAX)
            wait_nxt = wait_cnt + 8'd1;
        case (state)
            PL_PRI:   if (!host_gnt && wait_cnt == WAIT_MAX) state_nxt = HOST_PRI;
            HOST_PRI: if (host_gnt) state_nxt = PL_PRI;
            default:  state_nxt = PL_PRI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PL_PRI;
            wait_cnt   <= 8'd0;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            tag_vld    <= '0;
            tag_host   <= '0;
            pl_hold    <= '0;
            hr_hold    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            sram_ce  <= pl_gnt | host_gnt;
            sram_we  <= (pl_gnt & pl_we) | hw_gnt;
            if (pl_gnt) begin
                sram_addr <= pl_addr;
                if (pl_we) sram_wdata <= pl_wdata;
            end else if (hw_gnt) begin
                sram_addr  <= hw_addr;
                sram_wdata <= hw_wdata;
            end else if (hr_gnt) begin
                sram_addr <= hr_addr;
            end
            // Tag tail lines up with the cycle the SRAM presents the read data.
            tag_vld  <= {tag_vld[RD_LAT-1:0], rd_push};
            tag_host <= {tag_host[RD_LAT-1:0], hr_gnt};
            if (pl_rvalid) pl_hold <= sram_rdata;
            if (hr_rvalid) hr_hold <= sram_rdata;
        end
    end

    assign pl_rvalid    = tag_vld[RD_LAT] & ~tag_host[RD_LAT] & ~rst;
    assign hr_rvalid    = tag_vld[RD_LAT] &  tag_host[RD_LAT] & ~rst;
    assign pl_rdata     = pl_rvalid ? sram_rdata : pl_hold;
    assign hr_rdata     = hr_rvalid ? sram_rdata : hr_hold;
    assign host_starved = (state == HOST_PRI);

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Single-port arbiter that shares the external 8-bit frame SRAM between the SIFT pipeline (frame writer and feature readers) and the EPP host port (image upload writes and result readback reads). It accepts one access per clock from three requesters. It issues registered commands to the SRAM and routes read data back to the issuing requester after a fixed latency. A starvation counter guarantees forward progress for the host, even while the pipeline streams a frame continuously.

## Interface
- AW, 23, SRAM address width (512×512 image plus result areas)
- DW, 8, data width
- RD_LAT, 2, cycles from SRAM command register to valid `sram_rdata` (range 1–4)
- MAX_WAIT, 15, host wait cycles before host is promoted above pipeline (range 1–255)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- pl_req / pl_we  in  1 / 1  pipeline request; 1 = write
- pl_addr / pl_wdata  in  AW / DW  pipeline address and write data
- pl_gnt  out  1  pipeline request accepted this cycle
- pl_rvalid / pl_rdata  out  1 / DW  pipeline read return
- hw_req  in  1  host write request
- hw_addr / hw_wdata  in  AW / DW  host write address and data
- hw_gnt  out  1  host write accepted
- hr_req  in  1  host read request
- hr_addr  in  AW  host read address
- hr_gnt  out  1  host read accepted
- hr_rvalid / hr_rdata  out  1 / DW  host read return
- sram_ce / sram_we  out  1 / 1  registered SRAM command strobe and write enable
- sram_addr / sram_wdata  out  AW / DW  registered SRAM address and write data
- sram_rdata  in  DW  SRAM read data, valid RD_LAT cycles after its command
- host_starved  out  1  high while arbiter is in HOST_PRI

## Operation
- Handshake: a requester raises req with stable payload and holds it until it samples gnt=1. The transfer completes in that cycle. Payload may change the next cycle.
- gnt is combinational from the req lines and the registered state. At most one gnt is high per cycle. A gnt is never high without its req.
- States:
  - PL_PRI (reset state): priority is pl > hw > hr.
  - HOST_PRI: priority is hw > hr > pl.
- wait_cnt (8 bit):
  - Cleared on reset and on any hw_gnt or hr_gnt.
  - Otherwise increments in each cycle where (hw_req|hr_req) is high and no host gnt is given.
  - Saturates at MAX_WAIT.
- Transitions:
  - PL_PRI→HOST_PRI on the edge where wait_cnt reaches MAX_WAIT.
  - HOST_PRI→PL_PRI on the edge after any host gnt. The host therefore gets exactly one promoted slot per starvation event.
- A granted access loads sram_ce=1, sram_we, sram_addr and sram_wdata on the next edge. With no grant, sram_ce=0 and sram_we=0; address and data hold.
- Read tag: a shift register of depth RD_LAT+1 carries {valid, owner} for each read (owner: pl/hr).
  - When the tag emerges, the matching *_rvalid pulses for one cycle, with *_rdata = sram_rdata (combinational pass-through).
  - Writes push no tag.
- Reads and writes to the same address issue in grant order. No reordering and no write buffering.
- *_rdata holds its last value when *_rvalid=0.

## Timing
- Accesses are accepted back-to-back, one per cycle. Full throughput for a single requester.
- Read latency: gnt in cycle N → sram_ce in cycle N+1 → *_rvalid in cycle N+1+RD_LAT.
- Write: gnt in cycle N → sram_ce=sram_we=1 in cycle N+1.
- Reset values: every output is 0, state is PL_PRI, wait_cnt is 0, and all tags are cleared.
- Reset mid-operation:
  - In-flight reads are dropped; no rvalid appears after reset.
  - gnt stays low in any cycle where rst=1.
- Simultaneous events:
  - If the host gets a gnt in the same cycle wait_cnt would saturate, the clear wins and state stays PL_PRI.
  - If hw and hr both request in HOST_PRI, hw wins; the arbiter returns to PL_PRI and hr keeps counting from 0.
- Idle: with no req, no state change and sram_ce=0.

## Test plan
- Pipeline-only writes:
  - Stimulus: pl_req held with addresses 0..3, we=1.
  - Required: pl_gnt high 4 consecutive cycles; sram_ce=sram_we=1 one cycle later with addresses 0,1,2,3.
- Host read latency (RD_LAT=2):
  - Stimulus: hr_req at addr 0x00100, gnt in cycle 10; SRAM model drives 0xA5 on sram_rdata in cycle 13.
  - Required: hr_rvalid=1 in cycle 13 only, with hr_rdata=0xA5; pl_rvalid stays 0.
- Starvation:
  - Stimulus: pl_req held continuously; hw_req raised in cycle 0.
  - Required: hw_gnt in cycle MAX_WAIT+1 (16); pl_gnt low in that cycle only; host_starved high during that cycle and low after.
- Priority in HOST_PRI:
  - Stimulus: hw_req and hr_req both held under continuous pl_req.
  - Required: hw granted first; hr granted after a further MAX_WAIT+1 cycles.
- Interleaved read owners:
  - Stimulus: alternate pl read and hr read grants every cycle.
  - Required: rvalid alternates pl/hr in the same order, RD_LAT+1 cycles after each grant.
- Reset with reads in flight:
  - Stimulus: rst=1 for 1 cycle, the cycle after two read grants.
  - Required: no rvalid follows; all outputs are 0 in the cycle after reset; state is PL_PRI.
